imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
Loads the Processor's instruction memory from a byte stream before execution, then releases the core. Each group of four bytes is assembled into one 32-bit ARMv8 instruction word, little-endian. Every word is written to consecutive instruction-memory word addresses starting at 0. After the last word is written, the block asserts t_core_run so the Processor starts fetching. It sits between the bench/host byte source and the instruction-memory write port.

Parameters:
ADDR_W, 8, instruction-memory word-address width.
LOAD_WORDS, 64, number of 32-bit words per load; legal range 1..2^ADDR_W.

Ports:
t_clk  in  1  system clock; all logic on rising edge.
t_rst  in  1  synchronous, active-high reset.
t_start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
t_byte_valid  in  1  source has a byte on t_byte_data.
t_byte_data  in  8  stream byte.
t_byte_ready  out  1  loader accepts a byte this cycle.
t_imem_we  out  1  instruction-memory write strobe, one cycle per word.
t_imem_addr  out  ADDR_W  word address for the write.
t_imem_wdata  out  32  assembled instruction word.
t_busy  out  1  load in progress (LOAD or WRITE).
t_done  out  1  all LOAD_WORDS words written; held high.
t_core_run  out  1  core enable; low from reset or start until load completes.

Behaviour:
- Reset (synchronous, t_rst=1 at a rising edge): state=IDLE; byte_cnt=0; word_cnt=0; shift register=0; all outputs 0. Reset in any state, including mid-word or mid-write, aborts the load. Any partial word is discarded.
- Handshake: a byte transfers on a cycle where t_byte_valid && t_byte_ready. t_byte_ready is a registered function of state and is 1 only in LOAD. In IDLE, WRITE and DONE, valid bytes are not consumed and the source must hold them.
- States:
  - IDLE: core_run=0. t_start goes to LOAD and clears byte_cnt and word_cnt.
  - LOAD: busy=1, ready=1. Each accepted byte goes to lane byte_cnt: first byte to bits[7:0], fourth byte to bits[31:24]; then byte_cnt increments. Acceptance of the 4th byte (byte_cnt==3) goes to WRITE and resets byte_cnt to 0. With valid held low, the block waits indefinitely in LOAD.
  - WRITE (exactly 1 cycle): we=1, addr=word_cnt, wdata=assembled word, ready=0. Write latency is the cycle after the 4th byte is accepted. If word_cnt==LOAD_WORDS-1, go to DONE; otherwise increment word_cnt and return to LOAD.
  - DONE: done=1, core_run=1, busy=0, we=0. t_start goes to LOAD: done and core_run drop on the next cycle and the counters clear. Memory is overwritten from address 0.
- t_start while in LOAD or WRITE is ignored; no restart and no counter change.
- t_start together with t_rst: reset wins.
- Addresses: t_imem_addr never exceeds LOAD_WORDS-1, and no wrap-around occurs within a load. When LOAD_WORDS == 2^ADDR_W, the final address is all-ones.
- t_imem_addr and t_imem_wdata may hold stale values when we=0. Only values qualified by we are meaningful.
- Throughput: with valid held high, one word takes 5 cycles (4 accept + 1 write). A full load takes 5*LOAD_WORDS cycles from the first LOAD cycle.

Test Plan:
1. LOAD_WORDS=2. Pulse start, then stream 78 56 34 12 EF BE AD DE with valid high. Required: we at addr 0 with data 0x12345678, then we at addr 1 with data 0xDEADBEEF. done and core_run rise the cycle after the second write, exactly 10 cycles after the first LOAD cycle.
2. Backpressure/gaps: same stream with valid toggled 1,0,1,0. Required: bytes consumed only when valid&&ready, identical writes, and ready=0 during each WRITE cycle, so the 5th byte is held and not lost.
3. Ignored start: pulse start after 2 bytes of word 0. Required: no restart; word 0 still equals 0x12345678 at addr 0.
4. Mid-load reset: assert t_rst after 3 bytes. Required: next cycle all outputs 0 and state IDLE. A new start plus 4 bytes 01 00 00 00 writes 0x00000001 to addr 0, with no residue from the aborted bytes.
5. Reload from DONE: after test 1, pulse start. Required: core_run and done fall the next cycle. Stream AA BB CC DD 11 22 33 44: addr 0 gets 0xDDCCBBAA and addr 1 gets 0x44332211, then core_run rises again.
6. Idle source: valid=1 with byte 0x55 in IDLE and no start for 20 cycles. Required: ready=0 throughout, no we, and core_run=0.

Source files
------------

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - byte-stream instruction-memory loader with core release
//
// Purpose: assembles little-endian 32-bit words from a byte stream, writes
// them to consecutive instruction-memory word addresses from 0, and raises
// t_core_run once LOAD_WORDS words have been written.
//
// Ports:
//   t_clk, t_rst         clock and synchronous active-high reset
//   t_start              load request pulse (honoured in IDLE or DONE only)
//   t_byte_valid/data    incoming byte stream
//   t_byte_ready         byte accepted this cycle (LOAD state only)
//   t_imem_we/addr/wdata instruction-memory write port, one strobe per word
//   t_busy               load in progress (LOAD or WRITE)
//   t_done, t_core_run   load complete, core released; held until next start
module imem_stream_loader #(
    parameter int ADDR_W     = 8,
    parameter int LOAD_WORDS = 64
) (
    input  logic              t_clk,
    input  logic              t_rst,
    input  logic              t_start,
    input  logic              t_byte_valid,
    input  logic [7:0]        t_byte_data,
    output logic              t_byte_ready,
    output logic              t_imem_we,
    output logic [ADDR_W-1:0] t_imem_addr,
    output logic [31:0]       t_imem_wdata,
    output logic              t_busy,
    output logic              t_done,
    output logic              t_core_run
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Truncating cast keeps the all-ones final address when LOAD_WORDS == 2^ADDR_W.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]       word_q, word_d;

    logic byte_fire;
    logic start_ok;

    // Ready is decoded from the registered state, so it never depends on valid.
    assign byte_fire = t_byte_valid && (state_q == S_LOAD);
    assign start_ok  = t_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State and datapath registers.
    always_ff @(posedge t_clk) begin
        if (t_rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            word_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_LOAD;
            S_LOAD:  if (byte_fire && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
            S_WRITE: state_d = (word_cnt_q == LAST_ADDR) ? S_DONE : S_LOAD;
            S_DONE:  if (start_ok) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters and word assembly.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        if (start_ok) begin
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
            word_d     = 32'd0;
        end else if (byte_fire) begin
            case (byte_cnt_q)
                2'd0:    word_d[7:0]   = t_byte_data;
                2'd1:    word_d[15:8]  = t_byte_data;
                2'd2:    word_d[23:16] = t_byte_data;
                default: word_d[31:24] = t_byte_data;
            endcase
            // Two-bit counter wraps to 0 after the fourth byte.
            byte_cnt_d = byte_cnt_q + 2'd1;
        end else if ((state_q == S_WRITE) && (word_cnt_q != LAST_ADDR)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        t_byte_ready = (state_q == S_LOAD);
        t_imem_we    = (state_q == S_WRITE);
        t_busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
        t_done       = (state_q == S_DONE);
        t_core_run   = (state_q == S_DONE);
        t_imem_addr  = word_cnt_q;
        t_imem_wdata = word_q;
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - scoreboard bench for imem_stream_loader
module tb_imem_stream_loader;

    localparam int ADDR_W     = 8;
    localparam int LOAD_WORDS = 2;

    logic              clk = 1'b0;
    logic              t_rst;
    logic              t_start;
    logic              t_byte_valid;
    logic [7:0]        t_byte_data;
    logic              t_byte_ready;
    logic              t_imem_we;
    logic [ADDR_W-1:0] t_imem_addr;
    logic [31:0]       t_imem_wdata;
    logic              t_busy;
    logic              t_done;
    logic              t_core_run;

    imem_stream_loader #(.ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS)) dut (
        .t_clk        (clk),
        .t_rst        (t_rst),
        .t_start      (t_start),
        .t_byte_valid (t_byte_valid),
        .t_byte_data  (t_byte_data),
        .t_byte_ready (t_byte_ready),
        .t_imem_we    (t_imem_we),
        .t_imem_addr  (t_imem_addr),
        .t_imem_wdata (t_imem_wdata),
        .t_busy       (t_busy),
        .t_done       (t_done),
        .t_core_run   (t_core_run)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected word.
    always @(negedge clk) begin
        if (!t_rst && t_imem_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, none expected",
                         t_imem_addr, t_imem_wdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("write_addr", 32'(t_imem_addr), 32'(e.addr));
                chk("write_data", t_imem_wdata, e.data);
                chk("ready_in_write", 32'(t_byte_ready), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
    endtask

    // Hold a byte until it is accepted; optional one idle cycle after it.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        acc = 1'b0;
        t_byte_valid = 1'b1;
        t_byte_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = t_byte_ready;
            tick();
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
        if (gap) begin
            t_byte_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * k);
            send_byte(tmp[7:0], gap);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!t_done && n < 100) begin
            tick();
            n++;
        end
        if (!t_done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    int e0;
    int n;

    initial begin
        t_rst        = 1'b1;
        t_start      = 1'b0;
        t_byte_valid = 1'b0;
        t_byte_data  = 8'h00;
        tick();
        tick();
        t_rst = 1'b0;

        // Reset state.
        chk("rst_ready", 32'(t_byte_ready), 32'd0);
        chk("rst_we", 32'(t_imem_we), 32'd0);
        chk("rst_busy", 32'(t_busy), 32'd0);
        chk("rst_done", 32'(t_done), 32'd0);
        chk("rst_core_run", 32'(t_core_run), 32'd0);
        chk("rst_addr", 32'(t_imem_addr), 32'd0);
        chk("rst_wdata", t_imem_wdata, 32'd0);

        // Idle source: valid byte present, no start.
        t_byte_valid = 1'b1;
        t_byte_data  = 8'h55;
        for (int i = 0; i < 20; i++) begin
            chk("idle_ready", 32'(t_byte_ready), 32'd0);
            chk("idle_core_run", 32'(t_core_run), 32'd0);
            tick();
        end
        t_byte_valid = 1'b0;

        // Basic load with valid held high and timing check.
        expect_write(8'd0, 32'h12345678);
        expect_write(8'd1, 32'hDEADBEEF);
        pulse_start();
        e0 = cyc;
        chk("load_busy", 32'(t_busy), 32'd1);
        send_word(32'h12345678, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        t_byte_valid = 1'b0;
        wait_done(n);
        chk("done_latency", 32'(cyc - e0), 32'd10);
        chk("core_run_after_load", 32'(t_core_run), 32'd1);
        chk("busy_in_done", 32'(t_busy), 32'd0);
        wait_drain();

        // Reload from DONE.
        expect_write(8'd0, 32'hDDCCBBAA);
        expect_write(8'd1, 32'h44332211);
        pulse_start();
        chk("reload_done_drop", 32'(t_done), 32'd0);
        chk("reload_core_run_drop", 32'(t_core_run), 32'd0);
        send_word(32'hDDCCBBAA, 1'b0);
        send_word(32'h44332211, 1'b0);
        t_byte_valid = 1'b0;
        wait_done(n);
        chk("reload_core_run", 32'(t_core_run), 32'd1);
        wait_drain();

        // Gapped stream: valid toggles 1,0,1,0.
        expect_write(8'd0, 32'h12345678);
        expect_write(8'd1, 32'hDEADBEEF);
        pulse_start();
        send_word(32'h12345678, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        wait_done(n);
        chk("gap_done", 32'(t_done), 32'd1);
        wait_drain();

        // Start during LOAD is ignored.
        expect_write(8'd0, 32'h12345678);
        expect_write(8'd1, 32'hCAFEF00D);
        pulse_start();
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        t_byte_valid = 1'b0;
        pulse_start();
        chk("ignored_start_busy", 32'(t_busy), 32'd1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        t_byte_valid = 1'b0;
        wait_done(n);
        wait_drain();

        // Mid-load reset after three bytes.
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        t_byte_valid = 1'b0;
        t_rst = 1'b1;
        tick();
        t_rst = 1'b0;
        chk("midrst_ready", 32'(t_byte_ready), 32'd0);
        chk("midrst_busy", 32'(t_busy), 32'd0);
        chk("midrst_we", 32'(t_imem_we), 32'd0);
        chk("midrst_done", 32'(t_done), 32'd0);
        chk("midrst_core_run", 32'(t_core_run), 32'd0);
        chk("midrst_addr", 32'(t_imem_addr), 32'd0);
        chk("midrst_wdata", t_imem_wdata, 32'd0);
        tick();
        chk("midrst_stays_idle", 32'(t_byte_ready), 32'd0);
        expect_write(8'd0, 32'h00000001);
        expect_write(8'd1, 32'h00000002);
        pulse_start();
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000002, 1'b0);
        t_byte_valid = 1'b0;
        wait_done(n);
        wait_drain();

        // Start together with reset: reset wins.
        t_rst   = 1'b1;
        t_start = 1'b1;
        tick();
        t_rst   = 1'b0;
        t_start = 1'b0;
        chk("rst_start_done", 32'(t_done), 32'd0);
        chk("rst_start_ready", 32'(t_byte_ready), 32'd0);
        tick();
        chk("rst_start_not_loading", 32'(t_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
